// File: rtl/cpu_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// bus widths and the fetch-word select bit.
package cpu_pkg;

    localparam int BUS_ADDR_W          = 64;
    localparam int BUS_DATA_W          = 64;
    localparam int BUS_STRB_W          = 8;
    localparam int INSTR_W             = 32;
    // Address bit choosing the upper or lower 32-bit word of a 64-bit beat
    localparam int FETCH_WORD_SEL_BIT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_IF  = 3'd1,
        ST_WAIT_IF = 3'd2,
        ST_REQ_LS  = 3'd3,
        ST_WAIT_LS = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_bus_rsp_reg.sv
// Registered response demux: turns a captured bus response into a one-cycle
// fetch or load/store response pulse, suppressing stale fetch data.
module mem_bus_rsp_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_capture,
    input  logic              if_drop,
    input  logic              if_sel_hi,
    input  logic              ls_capture,
    input  logic              ls_is_store,
    input  logic [DATA_W-1:0] bus_rsp_data,
    output logic              if_rsp_valid,
    output logic [INSTR_W-1:0] if_rsp_instr,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data
);

    logic if_deliver;

    assign if_deliver = if_capture & ~if_drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rsp_valid <= 1'b0;
            if_rsp_instr <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= '0;
        end else begin
            if_rsp_valid <= if_deliver;
            ls_rsp_valid <= ls_capture;
            if (if_deliver) begin
                if_rsp_instr <= if_sel_hi ? bus_rsp_data[2*INSTR_W-1:INSTR_W]
                                          : bus_rsp_data[INSTR_W-1:0];
            end
            // Stores only need an acknowledge, so their data field reads zero
            if (ls_capture) begin
                ls_rsp_data <= ls_is_store ? '0 : bus_rsp_data;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and load/store, one transaction at a time.
// Define MEM_ARB_FAIR_EN to bound how long fetch can be starved by the memory stage.
module mem_bus_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = BUS_ADDR_W,
    parameter int DATA_W       = BUS_DATA_W
`ifdef MEM_ARB_FAIR_EN
   ,parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req_valid,
    input  logic [ADDR_W-1:0]  if_req_addr,
    output logic               if_req_ready,
    input  logic               if_flush,
    output logic               if_rsp_valid,
    output logic [INSTR_W-1:0] if_rsp_instr,
    input  logic               ls_req_valid,
    input  logic               ls_req_we,
    input  logic [ADDR_W-1:0]  ls_req_addr,
    input  logic [DATA_W-1:0]  ls_req_wdata,
    input  logic [BUS_STRB_W-1:0] ls_req_wstrb,
    output logic               ls_req_ready,
    output logic               ls_rsp_valid,
    output logic [DATA_W-1:0]  ls_rsp_data,
    output logic               bus_req_valid,
    input  logic               bus_req_ready,
    output logic               bus_req_we,
    output logic [ADDR_W-1:0]  bus_req_addr,
    output logic [DATA_W-1:0]  bus_req_wdata,
    output logic [BUS_STRB_W-1:0] bus_req_wstrb,
    input  logic               bus_rsp_valid,
    input  logic [DATA_W-1:0]  bus_rsp_data,
    output logic               arb_o_fetch_stall,
    output logic               arb_o_mem_stall
);

    arb_state_t state_reg, state_next;

    logic                  we_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [BUS_STRB_W-1:0] wstrb_reg;
    logic                  drop_reg;

    logic is_idle, in_if, in_ls;
    logic fetch_wins, grant_if, grant_ls;

    assign is_idle = (state_reg == ST_IDLE);
    assign in_if   = (state_reg == ST_REQ_IF) || (state_reg == ST_WAIT_IF);
    assign in_ls   = (state_reg == ST_REQ_LS) || (state_reg == ST_WAIT_LS);

`ifdef MEM_ARB_FAIR_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_reg;
    logic                starved;

    assign starved    = (starve_reg == STARVE_W'(STARVE_LIMIT));
    assign fetch_wins = if_req_valid & ~if_flush & (~ls_req_valid | starved);

    // Counts memory-stage grants that overtook a waiting fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_reg <= '0;
        end else if (grant_if) begin
            starve_reg <= '0;
        end else if (grant_ls && if_req_valid && !starved) begin
            starve_reg <= starve_reg + 1'b1;
        end
    end
`else
    assign fetch_wins = if_req_valid & ~if_flush & ~ls_req_valid;
`endif

    assign grant_if = is_idle & fetch_wins;
    assign grant_ls = is_idle & ls_req_valid & ~fetch_wins;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (grant_ls)      state_next = ST_REQ_LS;
                else if (grant_if) state_next = ST_REQ_IF;
            end
            ST_REQ_IF:  if (bus_req_ready) state_next = ST_WAIT_IF;
            ST_WAIT_IF: if (bus_rsp_valid) state_next = ST_IDLE;
            ST_REQ_LS:  if (bus_req_ready) state_next = ST_WAIT_LS;
            ST_WAIT_LS: if (bus_rsp_valid) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Payload is captured only at grant, so requesters may change it freely afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
        end else if (grant_ls) begin
            we_reg    <= ls_req_we;
            addr_reg  <= ls_req_addr;
            wdata_reg <= ls_req_wdata;
            wstrb_reg <= ls_req_wstrb;
        end else if (grant_if) begin
            we_reg    <= 1'b0;
            addr_reg  <= if_req_addr;
            wdata_reg <= '0;
            wstrb_reg <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_reg <= 1'b0;
        end else if (state_reg == ST_WAIT_IF && bus_rsp_valid) begin
            drop_reg <= 1'b0;
        end else if (in_if && if_flush) begin
            drop_reg <= 1'b1;
        end
    end

    mem_bus_rsp_reg #(
        .DATA_W (DATA_W)
    ) u_rsp_reg (
        .clk          (clk),
        .rst          (rst),
        .if_capture   ((state_reg == ST_WAIT_IF) && bus_rsp_valid),
        .if_drop      (drop_reg | if_flush),
        .if_sel_hi    (addr_reg[FETCH_WORD_SEL_BIT]),
        .ls_capture   ((state_reg == ST_WAIT_LS) && bus_rsp_valid),
        .ls_is_store  (we_reg),
        .bus_rsp_data (bus_rsp_data),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_instr (if_rsp_instr),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rsp_data  (ls_rsp_data)
    );

    assign bus_req_valid = (state_reg == ST_REQ_IF) || (state_reg == ST_REQ_LS);
    assign bus_req_we    = we_reg;
    assign bus_req_addr  = addr_reg;
    assign bus_req_wdata = wdata_reg;
    assign bus_req_wstrb = wstrb_reg;

    // Combinational outputs are forced low while reset is held
    assign if_req_ready      = rst & grant_if;
    assign ls_req_ready      = rst & grant_ls;
    assign arb_o_mem_stall   = rst & (ls_req_valid | in_ls) & ~ls_rsp_valid;
    assign arb_o_fetch_stall = rst & (if_req_valid | in_if) & ~if_rsp_valid;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR_BUILD = 1'b1;
    localparam int LIMIT      = 4;
`else
    localparam bit FAIR_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_valid, if_req_ready, if_flush, if_rsp_valid;
    logic [63:0] if_req_addr;
    logic [31:0] if_rsp_instr;
    logic        ls_req_valid, ls_req_we, ls_req_ready, ls_rsp_valid;
    logic [63:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
    logic [7:0]  ls_req_wstrb;
    logic        bus_req_valid, bus_req_ready, bus_req_we, bus_rsp_valid;
    logic [63:0] bus_req_addr, bus_req_wdata, bus_rsp_data;
    logic [7:0]  bus_req_wstrb;
    logic        arb_o_fetch_stall, arb_o_mem_stall;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus, whether the bus took the request yet,
    // the captured payload, and the response due next cycle.
    int          m_owner;   // 0 none, 1 fetch, 2 load/store
    bit          m_on_bus;
    bit          m_we;
    logic [63:0] m_addr, m_wdata, m_ldata;
    logic [7:0]  m_wstrb;
    bit          m_drop, m_if_pulse, m_ls_pulse;
    logic [31:0] m_instr;
    int          m_starve;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .if_req_valid      (if_req_valid),
        .if_req_addr       (if_req_addr),
        .if_req_ready      (if_req_ready),
        .if_flush          (if_flush),
        .if_rsp_valid      (if_rsp_valid),
        .if_rsp_instr      (if_rsp_instr),
        .ls_req_valid      (ls_req_valid),
        .ls_req_we         (ls_req_we),
        .ls_req_addr       (ls_req_addr),
        .ls_req_wdata      (ls_req_wdata),
        .ls_req_wstrb      (ls_req_wstrb),
        .ls_req_ready      (ls_req_ready),
        .ls_rsp_valid      (ls_rsp_valid),
        .ls_rsp_data       (ls_rsp_data),
        .bus_req_valid     (bus_req_valid),
        .bus_req_ready     (bus_req_ready),
        .bus_req_we        (bus_req_we),
        .bus_req_addr      (bus_req_addr),
        .bus_req_wdata     (bus_req_wdata),
        .bus_req_wstrb     (bus_req_wstrb),
        .bus_rsp_valid     (bus_rsp_valid),
        .bus_rsp_data      (bus_rsp_data),
        .arb_o_fetch_stall (arb_o_fetch_stall),
        .arb_o_mem_stall   (arb_o_mem_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req_valid = 0; if_req_addr = '0; if_flush = 0;
        ls_req_valid = 0; ls_req_we = 0; ls_req_addr = '0;
        ls_req_wdata = '0; ls_req_wstrb = '0;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_data = '0;
    endtask

    task automatic model_reset();
        m_owner = 0; m_on_bus = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        m_wstrb = '0; m_drop = 0; m_if_pulse = 0; m_ls_pulse = 0;
        m_instr = '0; m_ldata = '0; m_starve = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_if_ready"},  if_req_ready, 0);
        chk({tag, "_ls_ready"},  ls_req_ready, 0);
        chk({tag, "_if_rsp"},    if_rsp_valid, 0);
        chk({tag, "_instr"},     if_rsp_instr, 0);
        chk({tag, "_ls_rsp"},    ls_rsp_valid, 0);
        chk({tag, "_ls_data"},   ls_rsp_data, 0);
        chk({tag, "_bus_valid"}, bus_req_valid, 0);
        chk({tag, "_bus_pay"},   {bus_req_we, bus_req_wstrb}, 0);
        chk({tag, "_bus_addr"},  bus_req_addr, 0);
        chk({tag, "_bus_wdata"}, bus_req_wdata, 0);
        chk({tag, "_stalls"},    {arb_o_fetch_stall, arb_o_mem_stall}, 0);
    endtask

    // Fetch wins IDLE only when the memory stage is silent, or (fair build) fetch is starved
    function automatic bit fetch_first();
        bit starved = 0;
`ifdef MEM_ARB_FAIR_EN
        starved = (m_starve == LIMIT);
`endif
        return if_req_valid && !if_flush && (!ls_req_valid || starved);
    endfunction

    task automatic settle();
        #1;
    endtask

    // Compare every output against the model, then advance one clock.
    task automatic tick();
        bit idle, e_ifr, e_lsr, e_bv;
        #1;
        idle  = (m_owner == 0);
        e_ifr = idle && fetch_first();
        e_lsr = idle && ls_req_valid && !fetch_first();
        e_bv  = (m_owner != 0) && !m_on_bus;
        chk("if_req_ready", if_req_ready, e_ifr);
        chk("ls_req_ready", ls_req_ready, e_lsr);
        chk("bus_req_valid", bus_req_valid, e_bv);
        if (e_bv) begin
            chk("bus_req_we", bus_req_we, m_we);
            chk("bus_req_addr", bus_req_addr, m_addr);
            chk("bus_req_wdata", bus_req_wdata, m_wdata);
            chk("bus_req_wstrb", bus_req_wstrb, m_wstrb);
        end
        chk("if_rsp_valid", if_rsp_valid, m_if_pulse);
        if (m_if_pulse) chk("if_rsp_instr", if_rsp_instr, m_instr);
        chk("ls_rsp_valid", ls_rsp_valid, m_ls_pulse);
        if (m_ls_pulse) chk("ls_rsp_data", ls_rsp_data, m_ldata);
        chk("mem_stall", arb_o_mem_stall, (ls_req_valid || m_owner == 2) && !m_ls_pulse);
        chk("fetch_stall", arb_o_fetch_stall, (if_req_valid || m_owner == 1) && !m_if_pulse);
        @(posedge clk);
        m_if_pulse = 0;
        m_ls_pulse = 0;
        if (idle) begin
            if (e_lsr) begin
                m_owner = 2; m_on_bus = 0; m_we = ls_req_we; m_addr = ls_req_addr;
                m_wdata = ls_req_wdata; m_wstrb = ls_req_wstrb;
`ifdef MEM_ARB_FAIR_EN
                if (if_req_valid && m_starve < LIMIT) m_starve++;
`endif
            end else if (e_ifr) begin
                m_owner = 1; m_on_bus = 0; m_we = 0; m_addr = if_req_addr;
                m_wdata = '0; m_wstrb = '0; m_starve = 0;
            end
        end else begin
            if (m_owner == 1 && if_flush) m_drop = 1;
            if (!m_on_bus) begin
                if (bus_req_ready) m_on_bus = 1;
            end else if (bus_rsp_valid) begin
                if (m_owner == 1) begin
                    if (!m_drop) begin
                        m_if_pulse = 1;
                        m_instr = m_addr[2] ? bus_rsp_data[63:32] : bus_rsp_data[31:0];
                    end
                end else begin
                    m_ls_pulse = 1;
                    m_ldata = m_we ? 64'd0 : bus_rsp_data;
                end
                m_owner = 0; m_drop = 0; m_on_bus = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int ng;
        bit exp_fetch;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        settle();
        chk_quiet("reset");
        rst = 1;

        // Single fetch at minimum latency, upper word selected by addr[2]
        if_req_valid = 1; if_req_addr = 64'h8000_0004; bus_req_ready = 1;
        settle(); chk("t1_accept", if_req_ready, 1);
        tick();
        if_req_valid = 0;
        settle(); chk("t1_bus_valid", bus_req_valid, 1); chk("t1_bus_addr", bus_req_addr, 64'h8000_0004);
        tick();
        bus_rsp_valid = 1; bus_rsp_data = 64'h1111_2222_3333_4444;
        settle(); chk("t1_no_early_rsp", if_rsp_valid, 0);
        tick();
        bus_rsp_valid = 0;
        settle(); chk("t1_rsp_valid", if_rsp_valid, 1); chk("t1_instr", if_rsp_instr, 32'h1111_2222);
        tick();
        settle(); chk("t1_pulse_end", if_rsp_valid, 0);
        tick();

        // Both request in IDLE: memory stage first, fetch once the bus is free again
        if_req_valid = 1; if_req_addr = 64'h100;
        ls_req_valid = 1; ls_req_addr = 64'h2000; ls_req_we = 0;
        settle(); chk("t2_ls_ready", ls_req_ready, 1); chk("t2_if_ready", if_req_ready, 0);
        tick();
        ls_req_valid = 0;
        tick();
        bus_rsp_valid = 1; bus_rsp_data = 64'hCAFE_F00D_0000_1234;
        tick();
        bus_rsp_valid = 0;
        settle(); chk("t2_ls_rsp", ls_rsp_valid, 1); chk("t2_ld_data", ls_rsp_data, 64'hCAFE_F00D_0000_1234);
        chk("t2_fetch_next", if_req_ready, 1);
        tick();
        if_req_valid = 0;
        tick();
        bus_rsp_valid = 1; bus_rsp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        bus_rsp_valid = 0;
        settle(); chk("t2_instr_lo", if_rsp_instr, 32'hCCCC_DDDD);
        tick();

        // Store held off by the bus for 3 cycles; requester changes inputs meanwhile
        ls_req_valid = 1; ls_req_we = 1; ls_req_addr = 64'h3008;
        ls_req_wdata = 64'hDEAD_BEEF_0123_4567; ls_req_wstrb = 8'h0F; bus_req_ready = 0;
        tick();
        ls_req_valid = 0; ls_req_wdata = 64'h0; ls_req_wstrb = 8'hFF; ls_req_addr = 64'h0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("t3_valid%0d", c), bus_req_valid, 1);
            chk($sformatf("t3_wdata%0d", c), bus_req_wdata, 64'hDEAD_BEEF_0123_4567);
            chk($sformatf("t3_wstrb%0d", c), bus_req_wstrb, 8'h0F);
            chk($sformatf("t3_stall%0d", c), arb_o_mem_stall, 1);
            tick();
        end
        bus_req_ready = 1;
        tick();
        bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_data = 64'h1234_5678_9ABC_DEF0;
        settle(); chk("t3_stall_wait", arb_o_mem_stall, 1);
        tick();
        bus_rsp_valid = 0;
        settle(); chk("t3_ack", ls_rsp_valid, 1); chk("t3_ack_data", ls_rsp_data, 0);
        chk("t3_stall_drop", arb_o_mem_stall, 0);
        tick();

        // Flush while waiting for fetch data: bus completes, response suppressed
        if_req_valid = 1; if_req_addr = 64'h40; bus_req_ready = 1;
        tick();
        if_req_valid = 0;
        tick();
        if_flush = 1;
        tick();
        if_flush = 0; bus_rsp_valid = 1; bus_rsp_data = 64'h5555_6666_7777_8888;
        tick();
        bus_rsp_valid = 0; if_req_valid = 1; if_req_addr = 64'h44;
        settle(); chk("t4_suppressed", if_rsp_valid, 0); chk("t4_back_idle", if_req_ready, 1);
        tick();
        if_req_valid = 0;
        tick();
        bus_rsp_valid = 1;
        tick();
        bus_rsp_valid = 0;
        settle(); chk("t4_next_fetch", if_rsp_valid, 1); chk("t4_next_instr", if_rsp_instr, 32'h5555_6666);
        tick();

        // Reset while waiting on a load; the late response must be ignored
        ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 64'h5000;
        tick();
        ls_req_valid = 0;
        tick();
        #2 rst = 0;
        settle();
        chk_quiet("t5_in_reset");
        @(negedge clk);
        rst = 1;
        model_reset();
        bus_rsp_valid = 1; bus_rsp_data = 64'hFFFF_0000_FFFF_0000;
        tick();
        bus_rsp_valid = 0;
        settle(); chk("t5_no_rsp", ls_rsp_valid, 0); chk("t5_bus_idle", bus_req_valid, 0);
        tick();

        // Both requesters held high: fetch gets every fifth grant only when fairness is built in
        if_req_valid = 1; if_req_addr = 64'h200; ls_req_valid = 1; ls_req_we = 0;
        ls_req_addr = 64'h6000; bus_req_ready = 1; bus_rsp_valid = 1; bus_rsp_data = 64'h77;
        ng = 0;
        for (int c = 0; c < 40; c++) begin
            settle();
            if (ls_req_ready || if_req_ready) begin
                exp_fetch = FAIR_BUILD && ((ng % 5) == 4);
                if (ng < 10) chk($sformatf("t6_grant%0d", ng), if_req_ready, exp_fetch);
                ng++;
            end
            tick();
        end
        chk("t6_grant_count", (ng >= 10), 1);

        // Random traffic, including unsolicited responses and flushes
        for (int c = 0; c < 400; c++) begin
            if_req_valid  = ($urandom_range(0, 99) < 50);
            if_req_addr   = {$urandom, $urandom};
            if_flush      = ($urandom_range(0, 99) < 12);
            ls_req_valid  = ($urandom_range(0, 99) < 40);
            ls_req_we     = $urandom_range(0, 1);
            ls_req_addr   = {$urandom, $urandom};
            ls_req_wdata  = {$urandom, $urandom};
            ls_req_wstrb  = 8'($urandom);
            bus_req_ready = ($urandom_range(0, 99) < 50);
            bus_rsp_valid = ($urandom_range(0, 99) < 40);
            bus_rsp_data  = {$urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
